apb_slave_bank: RTL and testbench
=================================

APB_SLAVE_BANK -- requirements
Module: apb_slave_bank

Interface
REQ-001 SHALL: hclk  input  1  single clock; all state updates on the rising edge.
REQ-002 SHALL: hresetn  input  1  asynchronous, active-low reset.
REQ-003 SHALL: psel  input  3  one-hot slave select; bit n selects bank n (n = 0..2).
REQ-004 SHALL: penable  input  1  APB access-phase strobe.
REQ-005 SHALL: paddr  input  32  byte address; paddr[5:2] is the word index, paddr[1:0] is ignored.
REQ-006 SHALL: pwrite  input  1  1 = write, 0 = read.
REQ-007 SHALL: pwdata  input  32  write data.
REQ-008 SHALL: prdata  output  32  registered read data.
REQ-009 SHALL: prot_err  output  1  sticky protocol-violation flag.
REQ-010 SHALL: oor_err  output  1  one-cycle pulse on an out-of-range access.
REQ-011 SHALL: xfer_count  output  16  count of completed legal transfers.

Function
REQ-012 SHALL: storage is 3 banks x 16 words x 32 bits, all words 0 after reset.
REQ-013 SHALL: the protocol FSM has states IDLE, SETUP, ACCESS.
REQ-014 SHALL: IDLE->SETUP when psel is one-hot and penable=0; SETUP->ACCESS when penable=1 and psel, paddr, pwrite equal their SETUP-cycle values.
REQ-015 SHALL: ACCESS->SETUP when psel is one-hot and penable=0 (back-to-back transfer); ACCESS->IDLE when psel=0.
REQ-016 SHALL: the following are violations: penable=1 in IDLE; psel not one-hot while nonzero; psel, paddr or pwrite changed between SETUP and ACCESS; penable=1 on the cycle after ACCESS.
REQ-017 SHALL: on any violation, prot_err is set to 1, the access is dropped (no write, no count), and the FSM returns to IDLE.
REQ-018 SHALL: prot_err is cleared only by reset.
REQ-019 SHALL: SETUP captures psel, paddr and pwrite into internal registers used for the comparison in REQ-014.
REQ-020 SHALL: a write commits pwdata to bank[sel][paddr[5:2]] on the clock edge that ends a legal ACCESS cycle; pwdata is sampled in ACCESS.
REQ-021 SHALL: for a read, prdata is loaded on the edge ending SETUP and is valid throughout ACCESS (zero wait states).
REQ-022 SHALL: prdata returns to 32'h0 on the edge ending ACCESS and is 0 whenever no read is in ACCESS.
REQ-023 SHALL: a read in SETUP that immediately follows a write to the same word returns the newly written value.
REQ-024 SHALL: out of range means paddr[31:6] != 0.
REQ-025 SHALL: for an out-of-range access, writes are ignored, reads return 32'h0, oor_err pulses high for the ACCESS cycle, and xfer_count still increments.
REQ-026 SHALL: xfer_count increments by 1 on each legal ACCESS completion and wraps from 16'hFFFF to 16'h0000.
REQ-027 SHALL: a 2-bit psel value (for example 3'b011) in SETUP is a violation even if penable is correct.

Reset
REQ-028 SHALL: hresetn=0 asynchronously forces FSM=IDLE, prdata=0, prot_err=0, oor_err=0, xfer_count=0, all bank words=0 and all capture registers=0.
REQ-029 SHALL: a reset asserted during SETUP or ACCESS aborts the transfer with no write committed.
REQ-030 SHALL: after reset deassertion the first legal SETUP is accepted on the next clock edge.

Verification
REQ-031 SHALL: write 32'hA5A5_0001 to bank 1 at paddr 0x08, then read the same address -> prdata = 32'hA5A5_0001 during ACCESS, and xfer_count = 2.
REQ-032 SHALL: back-to-back writes to bank 0 at 0x00 and 0x04 (ACCESS->SETUP with no IDLE), then reads of both -> both values returned, and xfer_count = 4.
REQ-033 SHALL: change paddr 0x10->0x14 between SETUP and ACCESS on a write -> prot_err = 1 and a read of 0x10 and 0x14 returns 0.
REQ-034 SHALL: read at paddr 32'h0000_0040 on bank 2 -> prdata = 0, oor_err high for 1 cycle, and xfer_count increments.
REQ-035 SHALL: assert hresetn=0 mid-ACCESS of a write of 32'hFFFF_FFFF -> all outputs are 0 immediately, and a later read of that word returns 0.
REQ-036 SHALL: preload xfer_count to 16'hFFFF via 65535 transfers and run 1 more -> xfer_count = 16'h0000.

Source files
------------

// File: rtl/apb_slave_bank.sv
// APB slave with three 16x32 register banks selected by a one-hot psel.
// Checks the setup/access handshake, flags violations (sticky) and out-of-range accesses (pulse).
module apb_slave_bank (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic [2:0]  psel,
  input  logic        penable,
  input  logic [31:0] paddr,
  input  logic        pwrite,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        prot_err,
  output logic        oor_err,
  output logic [15:0] xfer_count
);

  localparam int unsigned NBANK = 3;
  localparam int unsigned NWORD = 16;
  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 32;
  localparam int unsigned SW    = 3;
  localparam int unsigned BW    = 2;
  localparam int unsigned IW    = 4;
  localparam int unsigned CW    = 16;

  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            write_q, write_d;
  logic [DW-1:0]   prdata_q, prdata_d;
  logic            prot_q, prot_d;
  logic            oor_q, oor_d;
  logic [CW-1:0]   count_q, count_d;
  logic [DW-1:0]   mem_q [NBANK][NWORD];

  logic            sel_onehot_c;
  logic            sel_multi_c;
  logic            in_range_c;
  logic            viol_c;
  logic            setup_go_c;
  logic            access_done_c;
  logic            wr_en_c;
  logic [DW-1:0]   rd_word_c;

  // One-hot select to bank number; non-one-hot values never reach a bank access.
  function automatic logic [BW-1:0] bank_idx(input logic [SW-1:0] s);
    case (s)
      3'b010:  bank_idx = BW'(1);
      3'b100:  bank_idx = BW'(2);
      default: bank_idx = BW'(0);
    endcase
  endfunction

  assign sel_onehot_c = (psel == 3'b001) || (psel == 3'b010) || (psel == 3'b100);
  assign sel_multi_c  = (psel != '0) && !sel_onehot_c;
  assign in_range_c   = (paddr[AW-1:6] == '0);

  // State register
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state: state tracks the phase the bus was in on the previous cycle
  always_comb begin
    viol_c        = 1'b0;
    setup_go_c    = 1'b0;
    access_done_c = 1'b0;
    state_d       = IDLE;
    case (state_q)
      IDLE, ACCESS: begin
        if (penable || sel_multi_c) viol_c = 1'b1;
        else if (sel_onehot_c)      setup_go_c = 1'b1;
      end
      SETUP: begin
        if (!penable || (psel != sel_q) || (paddr != addr_q) || (pwrite != write_q))
          viol_c = 1'b1;
        else
          access_done_c = 1'b1;
      end
      default: viol_c = 1'b1;
    endcase
    if (viol_c)             state_d = IDLE;
    else if (setup_go_c)    state_d = SETUP;
    else if (access_done_c) state_d = ACCESS;
  end

  // Outputs and datapath next values
  always_comb begin
    rd_word_c = mem_q[bank_idx(psel)][paddr[IW+1:2]];
    sel_d     = sel_q;
    addr_d    = addr_q;
    write_d   = write_q;
    prdata_d  = '0;
    oor_d     = 1'b0;
    prot_d    = prot_q | viol_c;
    count_d   = count_q + CW'(access_done_c);
    wr_en_c   = access_done_c && write_q && (addr_q[AW-1:6] == '0);
    if (setup_go_c) begin
      sel_d   = psel;
      addr_d  = paddr;
      write_d = pwrite;
      oor_d   = !in_range_c;
      if (!pwrite && in_range_c) prdata_d = rd_word_c;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      sel_q    <= '0;
      addr_q   <= '0;
      write_q  <= 1'b0;
      prdata_q <= '0;
      prot_q   <= 1'b0;
      oor_q    <= 1'b0;
      count_q  <= '0;
    end else begin
      sel_q    <= sel_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      prdata_q <= prdata_d;
      prot_q   <= prot_d;
      oor_q    <= oor_d;
      count_q  <= count_d;
    end
  end

  // Bank storage; written on the edge that completes a legal in-range write access
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      for (int b = 0; b < int'(NBANK); b++)
        for (int w = 0; w < int'(NWORD); w++)
          mem_q[b][w] <= '0;
    end else if (wr_en_c) begin
      mem_q[bank_idx(sel_q)][addr_q[IW+1:2]] <= pwdata;
    end
  end

  assign prdata     = prdata_q;
  assign prot_err   = prot_q;
  assign oor_err    = oor_q;
  assign xfer_count = count_q;

endmodule

// File: tb/tb_apb_slave_bank.sv
// Directed bench for apb_slave_bank: legal transfers, violations, out-of-range, reset abort, counter wrap.
module tb_apb_slave_bank;

  logic        hclk;
  logic        hresetn;
  logic [2:0]  psel;
  logic        penable;
  logic [31:0] paddr;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        prot_err;
  logic        oor_err;
  logic [15:0] xfer_count;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] rd;
  logic        rd_oor;

  apb_slave_bank dut (
    .hclk       (hclk),
    .hresetn    (hresetn),
    .psel       (psel),
    .penable    (penable),
    .paddr      (paddr),
    .pwrite     (pwrite),
    .pwdata     (pwdata),
    .prdata     (prdata),
    .prot_err   (prot_err),
    .oor_err    (oor_err),
    .xfer_count (xfer_count)
  );

  initial begin
    hclk = 1'b0;
    forever #5 hclk = ~hclk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic bus_idle();
    psel = 3'b000; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
  endtask

  task automatic do_reset();
    bus_idle();
    hresetn = 1'b0;
    @(negedge hclk);
    @(negedge hclk);
    hresetn = 1'b1;
  endtask

  task automatic idle_cycle();
    bus_idle();
    @(negedge hclk);
  endtask

  task automatic wr(input logic [2:0] s, input logic [31:0] a, input logic [31:0] d);
    psel = s; paddr = a; pwrite = 1'b1; pwdata = d; penable = 1'b0;
    @(negedge hclk);
    penable = 1'b1;
    @(negedge hclk);
  endtask

  task automatic rdx(input logic [2:0] s, input logic [31:0] a,
                     output logic [31:0] data, output logic oor);
    psel = s; paddr = a; pwrite = 1'b0; pwdata = '0; penable = 1'b0;
    @(negedge hclk);
    penable = 1'b1;
    data = prdata;
    oor  = oor_err;
    @(negedge hclk);
  endtask

  initial begin
    bus_idle();
    hresetn = 1'b0;
    @(negedge hclk);
    chk("rst_prdata", prdata, 32'h0);
    chk("rst_prot", 32'(prot_err), 32'h0);
    chk("rst_oor", 32'(oor_err), 32'h0);
    chk("rst_count", 32'(xfer_count), 32'h0);
    hresetn = 1'b1;

    // Write then read back on bank 1
    wr(3'b010, 32'h08, 32'hA5A5_0001);
    idle_cycle();
    rdx(3'b010, 32'h08, rd, rd_oor);
    chk("b1_rd_data", rd, 32'hA5A5_0001);
    chk("b1_rd_oor", 32'(rd_oor), 32'h0);
    chk("b1_count", 32'(xfer_count), 32'd2);
    chk("prdata_zero_after_access", prdata, 32'h0);
    idle_cycle();

    // Back-to-back writes and reads on bank 0, plus bank isolation
    do_reset();
    wr(3'b001, 32'h00, 32'h1111_0000);
    wr(3'b001, 32'h04, 32'h2222_0004);
    idle_cycle();
    rdx(3'b001, 32'h00, rd, rd_oor);
    chk("b0_rd0", rd, 32'h1111_0000);
    rdx(3'b001, 32'h04, rd, rd_oor);
    chk("b0_rd4", rd, 32'h2222_0004);
    idle_cycle();
    chk("b2b_count", 32'(xfer_count), 32'd4);
    rdx(3'b010, 32'h00, rd, rd_oor);
    chk("bank_isolation", rd, 32'h0);
    chk("no_prot_legal", 32'(prot_err), 32'h0);

    // Read immediately after write to the same word, with ignored low address bits
    wr(3'b100, 32'h3C, 32'hDEAD_BEEF);
    rdx(3'b100, 32'h3F, rd, rd_oor);
    chk("wr_then_rd", rd, 32'hDEAD_BEEF);
    idle_cycle();

    // Address changed between setup and access
    do_reset();
    psel = 3'b001; paddr = 32'h10; pwrite = 1'b1; pwdata = 32'hCAFE_0010; penable = 1'b0;
    @(negedge hclk);
    paddr = 32'h14; penable = 1'b1;
    @(negedge hclk);
    chk("addr_chg_prot", 32'(prot_err), 32'h1);
    chk("addr_chg_count", 32'(xfer_count), 32'h0);
    idle_cycle();
    rdx(3'b001, 32'h10, rd, rd_oor);
    chk("addr_chg_rd10", rd, 32'h0);
    rdx(3'b001, 32'h14, rd, rd_oor);
    chk("addr_chg_rd14", rd, 32'h0);
    idle_cycle();
    chk("prot_sticky", 32'(prot_err), 32'h1);
    chk("post_viol_count", 32'(xfer_count), 32'd2);

    // pwrite changed between setup and access
    do_reset();
    psel = 3'b010; paddr = 32'h20; pwrite = 1'b1; pwdata = 32'h1234_5678; penable = 1'b0;
    @(negedge hclk);
    pwrite = 1'b0; penable = 1'b1;
    @(negedge hclk);
    chk("wr_chg_prot", 32'(prot_err), 32'h1);
    idle_cycle();
    rdx(3'b010, 32'h20, rd, rd_oor);
    chk("wr_chg_no_write", rd, 32'h0);
    idle_cycle();

    // Two-bit select during setup
    do_reset();
    psel = 3'b011; paddr = 32'h00; pwrite = 1'b1; pwdata = 32'h5555_5555; penable = 1'b0;
    @(negedge hclk);
    penable = 1'b1;
    @(negedge hclk);
    chk("multi_sel_prot", 32'(prot_err), 32'h1);
    chk("multi_sel_count", 32'(xfer_count), 32'h0);
    idle_cycle();

    // penable high in IDLE
    do_reset();
    psel = 3'b001; penable = 1'b1; pwrite = 1'b1; paddr = 32'h0;
    @(negedge hclk);
    chk("en_in_idle_prot", 32'(prot_err), 32'h1);
    idle_cycle();

    // penable held high on the cycle after ACCESS
    do_reset();
    wr(3'b100, 32'h04, 32'h0BAD_F00D);
    penable = 1'b1;
    @(negedge hclk);
    chk("en_after_access_prot", 32'(prot_err), 32'h1);
    chk("en_after_access_count", 32'(xfer_count), 32'd1);
    idle_cycle();

    // Out-of-range read and write
    do_reset();
    rdx(3'b100, 32'h0000_0040, rd, rd_oor);
    chk("oor_rd_data", rd, 32'h0);
    chk("oor_pulse", 32'(rd_oor), 32'h1);
    chk("oor_count", 32'(xfer_count), 32'd1);
    chk("oor_pulse_end", 32'(oor_err), 32'h0);
    wr(3'b100, 32'h0000_0040, 32'hFFFF_FFFF);
    idle_cycle();
    rdx(3'b100, 32'h00, rd, rd_oor);
    chk("oor_wr_ignored", rd, 32'h0);
    chk("in_range_no_oor", 32'(rd_oor), 32'h0);
    idle_cycle();
    chk("oor_prot_clear", 32'(prot_err), 32'h0);

    // Reset asserted mid-ACCESS of a write
    do_reset();
    wr(3'b001, 32'h00, 32'h0000_0001);
    penable = 1'b1;
    @(negedge hclk);
    bus_idle();
    @(negedge hclk);
    chk("pre_abort_prot", 32'(prot_err), 32'h1);
    chk("pre_abort_count", 32'(xfer_count), 32'd1);
    psel = 3'b001; paddr = 32'h0C; pwrite = 1'b1; pwdata = 32'hFFFF_FFFF; penable = 1'b0;
    @(negedge hclk);
    penable = 1'b1;
    #2 hresetn = 1'b0;
    #1;
    chk("abort_prdata", prdata, 32'h0);
    chk("abort_prot", 32'(prot_err), 32'h0);
    chk("abort_oor", 32'(oor_err), 32'h0);
    chk("abort_count", 32'(xfer_count), 32'h0);
    @(negedge hclk);
    bus_idle();
    hresetn = 1'b1;
    rdx(3'b001, 32'h0C, rd, rd_oor);
    chk("abort_no_write", rd, 32'h0);
    rdx(3'b001, 32'h00, rd, rd_oor);
    chk("reset_clears_bank", rd, 32'h0);
    idle_cycle();

    // Counter wrap from 16'hFFFF
    do_reset();
    force dut.count_q = 16'hFFFF;
    @(negedge hclk);
    release dut.count_q;
    @(negedge hclk);
    chk("preload_count", 32'(xfer_count), 32'h0000_FFFF);
    wr(3'b010, 32'h10, 32'h0000_00AA);
    chk("wrap_count", 32'(xfer_count), 32'h0);
    wr(3'b010, 32'h14, 32'h0000_00BB);
    chk("post_wrap_count", 32'(xfer_count), 32'h1);
    idle_cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
